// File: rtl/sram_ctrl_pkg.sv
// Shared types and constants for the three-phase SRAM access controller.
// Optional build macro SRAM_ADX_CHECK_EN is consumed by sram_access_ctrl.
package sram_ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StPh1,
      StPh2,
      StPh3,
      StDone
   } sram_state_e;

   localparam int unsigned DefaultAdxW  = 11;
   localparam int unsigned DefaultDataW = 32;

   localparam logic OeReset  = 1'b1;
   localparam logic RnwReset = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter; the pointer names the preferred port when
// both request and moves to the other port whenever a grant is taken.
module rr_arb2
   import sram_ctrl_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       req0,
   input  logic       req1,
   input  logic       advance,
   output logic [1:0] grant
);

   logic ptr_q;

   always_comb begin
      grant = 2'b00;
      if (req0 && req1) begin
         grant = ptr_q ? 2'b10 : 2'b01;
      end else if (req0) begin
         grant = 2'b01;
      end else if (req1) begin
         grant = 2'b10;
      end
   end

   // After any grant the pointer favours the port that was not served.
   always_ff @(posedge clk) begin
      if (rst) begin
         ptr_q <= 1'b0;
      end else if (advance && (grant != 2'b00)) begin
         ptr_q <= grant[0];
      end
   end

endmodule

// File: rtl/sram_access_ctrl.sv
// Sequences the three-phase SRAM (address latch, MDR transfer, write commit) for two
// round-robin requesters. Define SRAM_ADX_CHECK_EN to reject addresses with the top bit set.
module sram_access_ctrl
   import sram_ctrl_pkg::*;
#(
   parameter int unsigned ADX_W  = DefaultAdxW,
   parameter int unsigned DATA_W = DefaultDataW
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Req0,
   input  logic              Req1,
   input  logic              RNW0,
   input  logic              RNW1,
   input  logic [ADX_W-1:0]  Adx0,
   input  logic [ADX_W-1:0]  Adx1,
   input  logic [DATA_W-1:0] WrData0,
   input  logic [DATA_W-1:0] WrData1,
   output logic              Ack0,
   output logic              Ack1,
   output logic [DATA_W-1:0] RdData0,
   output logic [DATA_W-1:0] RdData1,
   output logic              Err0,
   output logic              Err1,
   output logic [ADX_W-1:0]  SramAdx,
   output logic [DATA_W-1:0] SramDataOut,
   output logic              SramDataOutEn,
   input  logic [DATA_W-1:0] SramDataIn,
   output logic              SramOE,
   output logic              SramRNW,
   output logic              SramClk1,
   output logic              SramClk2,
   output logic              SramClk3
);

   sram_state_e state_q;
   logic        port_q;
   logic        rnw_q;

   logic [1:0]        grant;
   logic              g_any;
   logic              g_port;
   logic              g_rnw;
   logic [ADX_W-1:0]  g_adx;
   logic [DATA_W-1:0] g_wdata;

   rr_arb2 u_arb (
      .clk     (Clock),
      .rst     (Reset),
      .req0    (Req0),
      .req1    (Req1),
      .advance (state_q == StIdle),
      .grant   (grant)
   );

   always_comb begin
      g_any   = |grant;
      g_port  = grant[1];
      g_rnw   = g_port ? RNW1    : RNW0;
      g_adx   = g_port ? Adx1    : Adx0;
      g_wdata = g_port ? WrData1 : WrData0;
   end

   // Every output is registered and takes the value of the state being entered.
   always_ff @(posedge Clock) begin
      if (Reset) begin
         state_q       <= StIdle;
         port_q        <= 1'b0;
         rnw_q         <= 1'b1;
         Ack0          <= 1'b0;
         Ack1          <= 1'b0;
         RdData0       <= '0;
         RdData1       <= '0;
         SramAdx       <= '0;
         SramDataOut   <= '0;
         SramDataOutEn <= 1'b0;
         SramOE        <= OeReset;
         SramRNW       <= RnwReset;
         SramClk1      <= 1'b0;
         SramClk2      <= 1'b0;
         SramClk3      <= 1'b0;
`ifdef SRAM_ADX_CHECK_EN
         Err0          <= 1'b0;
         Err1          <= 1'b0;
`endif
      end else begin
         Ack0 <= 1'b0;
         Ack1 <= 1'b0;
`ifdef SRAM_ADX_CHECK_EN
         Err0 <= 1'b0;
         Err1 <= 1'b0;
`endif
         unique case (state_q)
            StIdle: begin
               if (g_any) begin
                  port_q <= g_port;
                  rnw_q  <= g_rnw;
`ifdef SRAM_ADX_CHECK_EN
                  // Out-of-range address: skip the SRAM entirely and report it.
                  if (g_adx[ADX_W-1]) begin
                     state_q <= StDone;
                     if (g_port) begin
                        Ack1 <= 1'b1;
                        Err1 <= 1'b1;
                     end else begin
                        Ack0 <= 1'b1;
                        Err0 <= 1'b1;
                     end
                  end else
`endif
                  begin
                     state_q  <= StPh1;
                     SramAdx  <= g_adx;
                     SramClk1 <= 1'b1;
                     SramRNW  <= g_rnw;
                     if (!g_rnw) begin
                        SramDataOut   <= g_wdata;
                        SramDataOutEn <= 1'b1;
                     end
                  end
               end
            end
            StPh1: begin
               state_q  <= StPh2;
               SramClk1 <= 1'b0;
               SramClk2 <= 1'b1;
            end
            StPh2: begin
               state_q  <= StPh3;
               SramClk2 <= 1'b0;
               if (rnw_q) begin
                  SramOE <= 1'b0;
               end else begin
                  SramClk3 <= 1'b1;
               end
            end
            StPh3: begin
               state_q       <= StDone;
               SramClk3      <= 1'b0;
               SramOE        <= 1'b1;
               SramRNW       <= 1'b1;
               SramDataOutEn <= 1'b0;
               if (port_q) begin
                  Ack1 <= 1'b1;
                  if (rnw_q) RdData1 <= SramDataIn;
               end else begin
                  Ack0 <= 1'b1;
                  if (rnw_q) RdData0 <= SramDataIn;
               end
            end
            StDone: begin
               state_q <= StIdle;
            end
            default: begin
               state_q <= StIdle;
            end
         endcase
      end
   end

`ifndef SRAM_ADX_CHECK_EN
   assign Err0 = 1'b0;
   assign Err1 = 1'b0;
`endif

endmodule

// File: tb/tb_sram_access_ctrl.sv
// Scoreboard bench for sram_access_ctrl against a behavioural three-phase SRAM model.
module tb_sram_access_ctrl;

   logic        Clock = 1'b0;
   logic        Reset = 1'b1;
   logic        Req0 = 1'b0, Req1 = 1'b0;
   logic        RNW0 = 1'b1, RNW1 = 1'b1;
   logic [10:0] Adx0 = '0, Adx1 = '0;
   logic [31:0] WrData0 = '0, WrData1 = '0;
   logic        Ack0, Ack1, Err0, Err1;
   logic [31:0] RdData0, RdData1;
   logic [10:0] SramAdx;
   logic [31:0] SramDataOut, SramDataIn;
   logic        SramDataOutEn, SramOE, SramRNW, SramClk1, SramClk2, SramClk3;

   sram_access_ctrl dut (
      .Clock(Clock), .Reset(Reset),
      .Req0(Req0), .Req1(Req1), .RNW0(RNW0), .RNW1(RNW1),
      .Adx0(Adx0), .Adx1(Adx1), .WrData0(WrData0), .WrData1(WrData1),
      .Ack0(Ack0), .Ack1(Ack1), .RdData0(RdData0), .RdData1(RdData1),
      .Err0(Err0), .Err1(Err1),
      .SramAdx(SramAdx), .SramDataOut(SramDataOut), .SramDataOutEn(SramDataOutEn),
      .SramDataIn(SramDataIn), .SramOE(SramOE), .SramRNW(SramRNW),
      .SramClk1(SramClk1), .SramClk2(SramClk2), .SramClk3(SramClk3)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   logic clk3_seen = 1'b0;
   logic [31:0] last_rd0;

   always @(posedge Clock) cyc <= cyc + 1;

   // SRAM model: only 10 address bits are decoded, so bit 10 aliases.
   logic [31:0] mem [0:1023];
   logic [9:0]  adx_l;
   logic [31:0] mdr;
   initial begin
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      adx_l = '0;
      mdr = '0;
   end
   always @(posedge Clock) begin
      if (SramClk1) adx_l <= SramAdx[9:0];
      if (SramClk2) mdr <= SramRNW ? mem[adx_l] : SramDataOut;
      if (SramClk3) mem[adx_l] <= mdr;
   end
   assign SramDataIn = !SramOE ? mdr : 32'h0BAD_0BAD;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        port;
      logic        chk_rd;
      logic [31:0] rd;
      logic        err;
      int          cyc;
   } exp_t;
   exp_t sb[$];

   // Monitor: pops an expectation on every Ack.
   always @(negedge Clock) begin
      exp_t e;
      check("bus_contention", {63'd0, SramDataOutEn && !SramOE}, 64'd0);
      if (SramClk3) clk3_seen = 1'b1;
      if (Ack0 || Ack1) begin
         check("ack_exclusive", {63'd0, Ack0 && Ack1}, 64'd0);
         if (sb.size() == 0) begin
            check("unexpected_ack", 64'd1, 64'd0);
         end else begin
            e = sb.pop_front();
            check("ack_port", {63'd0, Ack1}, {63'd0, e.port});
            check("ack_cycle", cyc, e.cyc);
            check("ack_err", {63'd0, e.port ? Err1 : Err0}, {63'd0, e.err});
            if (e.chk_rd) check("rd_data", e.port ? RdData1 : RdData0, e.rd);
         end
      end
   end

   task automatic check_reset_vals();
      check("rst_strobes", {61'd0, SramClk1, SramClk2, SramClk3}, 64'd0);
      check("rst_oe_rnw_en", {61'd0, SramOE, SramRNW, SramDataOutEn}, 64'b110);
      check("rst_adx", SramAdx, 64'd0);
      check("rst_dout", SramDataOut, 64'd0);
      check("rst_ack_err", {60'd0, Ack0, Ack1, Err0, Err1}, 64'd0);
      check("rst_rd0", RdData0, 64'd0);
      check("rst_rd1", RdData1, 64'd0);
   endtask

   task automatic do_reset();
      Reset = 1'b1;
      Req0 = 1'b0;
      Req1 = 1'b0;
      @(posedge Clock);
      @(negedge Clock);
      check_reset_vals();
      Reset = 1'b0;
   endtask

   // One access from an idle controller; checks per-cycle strobes, Ack via scoreboard.
   task automatic access(input logic port, input logic rnw, input logic [10:0] adx,
                         input logic [31:0] wd, input logic [31:0] exp_rd,
                         input logic exp_err);
      exp_t e;
      logic [4:0] exp_s;
      int n;
      @(posedge Clock);
      #1;
      if (port) begin
         Req1 = 1'b1; RNW1 = rnw; Adx1 = adx; WrData1 = wd;
      end else begin
         Req0 = 1'b1; RNW0 = rnw; Adx0 = adx; WrData0 = wd;
      end
      n = exp_err ? 1 : 4;
      e.port = port; e.chk_rd = rnw; e.rd = exp_rd; e.err = exp_err; e.cyc = cyc + n;
      sb.push_back(e);
      @(negedge Clock);
      for (int i = 1; i <= n; i++) begin
         @(negedge Clock);
         // {Clk1, Clk2, Clk3, OE, DataOutEn}
         if (exp_err)     exp_s = 5'b00010;
         else if (i == 1) exp_s = {4'b1001, !rnw};
         else if (i == 2) exp_s = {4'b0101, !rnw};
         else if (i == 3) exp_s = {2'b00, !rnw, !rnw, !rnw};
         else             exp_s = 5'b00010;
         check("strobes", {59'd0, SramClk1, SramClk2, SramClk3, SramOE, SramDataOutEn},
               {59'd0, exp_s});
         if (i == 1 && !exp_err) begin
            check("sram_adx", SramAdx, adx);
            check("sram_rnw", {63'd0, SramRNW}, {63'd0, rnw});
         end
      end
      Req0 = 1'b0;
      Req1 = 1'b0;
   endtask

   initial begin
      exp_t e;
      int k;
      do_reset();

      access(1'b0, 1'b0, 11'h005, 32'hDEADBEEF, 32'h0, 1'b0);
      access(1'b0, 1'b1, 11'h005, 32'h0, 32'hDEADBEEF, 1'b0);
      access(1'b0, 1'b0, 11'h3FF, 32'h12345678, 32'h0, 1'b0);
      access(1'b1, 1'b1, 11'h3FF, 32'h0, 32'h12345678, 1'b0);

      // Both ports held continuously: grants alternate 0,1,0,1 every 5 cycles.
      do_reset();
      @(posedge Clock);
      #1;
      Req0 = 1'b1; RNW0 = 1'b1; Adx0 = 11'h005;
      Req1 = 1'b1; RNW1 = 1'b1; Adx1 = 11'h3FF;
      k = cyc;
      for (int j = 0; j < 4; j++) begin
         e.port = j[0]; e.chk_rd = 1'b1; e.err = 1'b0; e.cyc = k + 4 + 5 * j;
         e.rd = j[0] ? 32'h12345678 : 32'hDEADBEEF;
         sb.push_back(e);
      end
      repeat (20) @(negedge Clock);
      Req0 = 1'b0;
      Req1 = 1'b0;

      // Reset during PH2 of a write must abort without Ack or commit.
      access(1'b0, 1'b0, 11'h010, 32'h11110000, 32'h0, 1'b0);
      @(posedge Clock);
      #1;
      Req0 = 1'b1; RNW0 = 1'b0; Adx0 = 11'h010; WrData0 = 32'hCAFEF00D;
      clk3_seen = 1'b0;
      repeat (3) @(negedge Clock);
      check("abort_in_ph2", {63'd0, SramClk2}, 64'd1);
      Reset = 1'b1;
      Req0 = 1'b0;
      @(negedge Clock);
      check_reset_vals();
      Reset = 1'b0;
      repeat (8) @(negedge Clock);
      check("abort_no_clk3", {63'd0, clk3_seen}, 64'd0);
      access(1'b0, 1'b1, 11'h010, 32'h0, 32'h11110000, 1'b0);
      last_rd0 = 32'h11110000;

      // Bit 10 of the address: aliased access, or rejected with Err when checking is built in.
      access(1'b0, 1'b0, 11'h000, 32'h0000A5A5, 32'h0, 1'b0);
`ifdef SRAM_ADX_CHECK_EN
      access(1'b0, 1'b1, 11'h400, 32'h0, last_rd0, 1'b1);
`else
      access(1'b0, 1'b1, 11'h400, 32'h0, 32'h0000A5A5, 1'b0);
`endif

      repeat (3) @(negedge Clock);
      check("sb_empty", sb.size(), 64'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_access_ctrl.md
Name: sram_access_ctrl

Overview:
- Single-clock controller that sequences the three-phase SRAM (address latch, MDR transfer, write commit) and shares it between two requesters.
- Typical requesters: port 0 = data/load-store, port 1 = instruction fetch.
- Generates the SRAM phase strobes, RNW, OE and write data from one system clock.
- Arbitrates round-robin and returns read data with a one-cycle Ack.

Parameters:
- ADX_W, 11, SRAM address width; forwarded unmodified, so bit 10 reaches the SRAM.
- DATA_W, 32, SRAM data width.

Ports:
- Clock  in  1  system clock; all logic on posedge.
- Reset  in  1  synchronous, active-high reset.
- Req0, Req1  in  1  access request; held high with fields stable until the matching Ack.
- RNW0, RNW1  in  1  1 = read, 0 = write.
- Adx0, Adx1  in  ADX_W  word address.
- WrData0, WrData1  in  DATA_W  write data.
- Ack0, Ack1  out  1  one-cycle completion pulse.
- RdData0, RdData1  out  DATA_W  read data; valid in the Ack cycle and held until that port's next Ack.
- Err0, Err1  out  1  error flag, qualified by Ack; tied 0 unless the optional feature is enabled.
- SramAdx  out  ADX_W  drives SRAM AdxBus.
- SramDataOut  out  DATA_W  write data toward the bus.
- SramDataOutEn  out  1  top level drives the bus with SramDataOut when 1, else high-Z.
- SramDataIn  in  DATA_W  bus value sampled for reads.
- SramOE  out  1  active-low SRAM output enable.
- SramRNW  out  1  SRAM read/not-write.
- SramClk1, SramClk2, SramClk3  out  1  SRAM phase strobes.

Behaviour:
- Clock and reset: single clock; reset is synchronous and active-high.
- Reset values: state IDLE; SramClk1/2/3=0; SramOE=1; SramRNW=1; SramDataOutEn=0; SramAdx=0; SramDataOut=0; Ack0/1=0; Err0/1=0; RdData0/1=0; round-robin pointer=0.
- Output timing: all outputs are registered and take their per-state value on the edge that enters the state.
- States: IDLE -> PH1 -> PH2 -> PH3 -> DONE -> IDLE.
- IDLE:
  - No request: stay.
  - Grant one requester: latch its RNW/Adx/WrData into internal registers and go to PH1.
- PH1:
  - SramAdx = latched address, SramClk1=1, SramRNW = latched RNW.
  - Write: SramDataOut = latched data, SramDataOutEn=1.
- PH2:
  - SramClk1=0, SramClk2=1.
  - Read: MDR loads from memory.
  - Write: MDR loads from the bus.
- PH3:
  - SramClk2=0.
  - Read: SramOE=0 so the SRAM drives the bus; SramDataIn is captured at the end of PH3. SramClk3 stays 0.
  - Write: SramClk3=1 commits the MDR; SramDataOutEn stays 1.
- DONE:
  - SramClk3=0, SramOE=1, SramRNW=1, SramDataOutEn=0.
  - Ack of the granted port = 1.
  - Read: that port's RdData updates with the captured value.
- Latency and throughput: Ack rises 4 cycles after the IDLE cycle in which the request was granted; one access per 5 cycles.
- Bus contention rule: SramDataOutEn and SramOE==0 must never both be asserted.
- Arbitration:
  - One request pending: grant it; pointer = the other port.
  - Both pending: grant the port the pointer selects; pointer toggles.
  - Requests arriving outside IDLE wait; they are not dropped.
- Requester protocol:
  - A requester still asserting Req in the cycle after Ack starts a new access.
  - Changing fields while Req is high before Ack is a protocol violation and is not detected.
- Reset mid-operation: abort immediately; no Ack; all outputs take reset values on that edge. A write aborted before PH3 never issues SramClk3.
- Width: SramAdx = Adx unmodified. The SRAM ignores bit 10, so 0x400 aliases 0x000 unless the optional feature is enabled.

Optional Feature:
- Macro: SRAM_ADX_CHECK_EN.
- Defined: a granted request with Adx[10]=1 goes IDLE -> DONE directly:
  - no SRAM strobes, RdData unchanged;
  - Ack and Err asserted together in the cycle after grant;
  - the pointer still toggles.
- Undefined: Err0/Err1 are constant 0 and address aliasing is unchecked.

Decomposition:
- Package sram_ctrl_pkg:
  - state enum (IDLE, PH1, PH2, PH3, DONE);
  - ADX_W/DATA_W defaults;
  - reset constants for SramOE/SramRNW.
- Sub-module rr_arb2: two-requester round-robin arbiter with pointer register.
  - Inputs: Req0, Req1, advance strobe.
  - Outputs: one-hot grant.

Test Plan:
- Port0 write Adx=0x005 WrData=0xDEADBEEF, then read 0x005 -> strobe order Clk1, Clk2, Clk3 on consecutive cycles; read has no Clk3; Ack0 at grant+4; RdData0=0xDEADBEEF.
- Write 0x12345678 to 0x3FF, read back -> 0x12345678, confirming both halves are stored.
- Req0 and Req1 both asserted after reset, held continuously -> grants 0,1,0,1; Acks 5 cycles apart; never both Acks in one cycle.
- Reset asserted in PH2 of a write to 0x010 holding 0xCAFEF00D -> no Ack; SramClk3 never rises; subsequent read of 0x010 returns the prior contents.
- Throughout all tests, assert that SramDataOutEn and !SramOE are never simultaneously 1.
- With SRAM_ADX_CHECK_EN defined, read Adx=0x400 -> Ack0 and Err0 in the cycle after grant; no SramClk1 pulse. Without the macro: full access and Err0=0.
